// File: rtl/dtm_jtag.sv
// ---------------------------------------------------------------------------------------------
// dtm_jtag: RISC-V JTAG debug transport module with a DMI initiator port.
//
// The JTAG pins are oversampled in the clk domain. tck, tms and tdi pass through two-flop
// synchronisers. Edges of the synchronised tck advance a 16-state IEEE 1149.1 TAP controller
// and shift the selected scan register. Scan registers: 5-bit IR, IDCODE, DTMCS, DMI and
// BYPASS. An Update-DR of the DMI register with a read or write op launches one DMI request.
// The request stays on dmi_* until it is accepted.
//
// Ports:
//   clk        system clock; all state is clocked on its rising edge
//   resetn     asynchronous active-low reset
//   tck/tms/tdi  JTAG inputs, asynchronous to clk (tck at most clk/8)
//   tdo        JTAG serial output, updated on tck falling edges while shifting
//   dmi_valid/dmi_ready  DMI request handshake
//   dmi_write  1 = write request, 0 = read request
//   dmi_addr   7-bit DMI address
//   dmi_wdata  32-bit write data
//   dmi_rdata  32-bit read data, sampled in the handshake cycle of a read
// ---------------------------------------------------------------------------------------------
module dtm_jtag #(
    parameter logic [31:0] IDCODE = 32'h1000_0001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    output logic        dmi_valid,
    input  logic        dmi_ready,
    output logic        dmi_write,
    output logic [6:0]  dmi_addr,
    output logic [31:0] dmi_wdata,
    input  logic [31:0] dmi_rdata
);

    typedef enum logic [3:0] {
        StTlr, StRti,
        StSelDr, StCapDr, StShiftDr, StExit1Dr, StPauseDr, StExit2Dr, StUpdDr,
        StSelIr, StCapIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir, StUpdIr
    } tap_state_e;

    localparam logic [4:0] IrIdcode = 5'h01;
    localparam logic [4:0] IrDtmcs  = 5'h10;
    localparam logic [4:0] IrDmi    = 5'h11;

    localparam logic [1:0] OpNop   = 2'd0;
    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] OpBusy  = 2'd3;

    // ---------------------------------------------------------------------------------------
    // Pin synchronisers. Bit order: {tdi, tms, tck}.
    // ---------------------------------------------------------------------------------------
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic       tck_prev_q, tck_prev_d;
    logic       tck_rise, tck_fall;
    logic       tms_s, tdi_s;

    always_comb begin
        sync1_d    = {tdi, tms, tck};
        sync2_d    = sync1_q;
        tck_prev_d = sync2_q[0];
    end

    assign tck_rise = sync2_q[0] & ~tck_prev_q;
    assign tck_fall = ~sync2_q[0] & tck_prev_q;
    assign tms_s    = sync2_q[1];
    assign tdi_s    = sync2_q[2];

    // ---------------------------------------------------------------------------------------
    // TAP controller: state register, next-state logic, state decode.
    // ---------------------------------------------------------------------------------------
    tap_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            unique case (state_q)
                StTlr:     state_d = tms_s ? StTlr     : StRti;
                StRti:     state_d = tms_s ? StSelDr   : StRti;
                StSelDr:   state_d = tms_s ? StSelIr   : StCapDr;
                StCapDr:   state_d = tms_s ? StExit1Dr : StShiftDr;
                StShiftDr: state_d = tms_s ? StExit1Dr : StShiftDr;
                StExit1Dr: state_d = tms_s ? StUpdDr   : StPauseDr;
                StPauseDr: state_d = tms_s ? StExit2Dr : StPauseDr;
                StExit2Dr: state_d = tms_s ? StUpdDr   : StShiftDr;
                StUpdDr:   state_d = tms_s ? StSelDr   : StRti;
                StSelIr:   state_d = tms_s ? StTlr     : StCapIr;
                StCapIr:   state_d = tms_s ? StExit1Ir : StShiftIr;
                StShiftIr: state_d = tms_s ? StExit1Ir : StShiftIr;
                StExit1Ir: state_d = tms_s ? StUpdIr   : StPauseIr;
                StPauseIr: state_d = tms_s ? StExit2Ir : StPauseIr;
                StExit2Ir: state_d = tms_s ? StUpdIr   : StShiftIr;
                StUpdIr:   state_d = tms_s ? StSelDr   : StRti;
                default:   state_d = StTlr;
            endcase
        end
    end

    logic st_tlr, st_cap_dr, st_shift_dr, st_upd_dr, st_cap_ir, st_shift_ir, st_upd_ir;

    always_comb begin
        st_tlr      = 1'b0;
        st_cap_dr   = 1'b0;
        st_shift_dr = 1'b0;
        st_upd_dr   = 1'b0;
        st_cap_ir   = 1'b0;
        st_shift_ir = 1'b0;
        st_upd_ir   = 1'b0;
        unique case (state_q)
            StTlr:     st_tlr      = 1'b1;
            StCapDr:   st_cap_dr   = 1'b1;
            StShiftDr: st_shift_dr = 1'b1;
            StUpdDr:   st_upd_dr   = 1'b1;
            StCapIr:   st_cap_ir   = 1'b1;
            StShiftIr: st_shift_ir = 1'b1;
            StUpdIr:   st_upd_ir   = 1'b1;
            default:   ;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Scan registers and DMI request state.
    // ---------------------------------------------------------------------------------------
    logic [4:0]  ir_q, ir_d;
    logic [4:0]  ir_shift_q, ir_shift_d;
    logic [40:0] dr_shift_q, dr_shift_d;
    logic        tdo_q, tdo_d;
    logic        dmi_valid_q, dmi_valid_d;
    logic        dmi_write_q, dmi_write_d;
    logic [6:0]  dmi_addr_q, dmi_addr_d;
    logic [31:0] dmi_wdata_q, dmi_wdata_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  dmistat_q, dmistat_d;

    logic [31:0] dtmcs_capture;
    logic [40:0] dmi_capture;
    logic [1:0]  dr_op;

    assign dtmcs_capture = {17'd0, 3'd1, dmistat_q, 6'd7, 4'd1};
    // dmi_addr_q doubles as the last launched address.
    assign dmi_capture   = {dmi_addr_q, result_q,
                            (dmi_valid_q || (dmistat_q != 2'd0)) ? OpBusy : OpNop};
    assign dr_op         = dr_shift_q[1:0];

    always_comb begin
        ir_d        = ir_q;
        ir_shift_d  = ir_shift_q;
        dr_shift_d  = dr_shift_q;
        tdo_d       = tdo_q;
        dmi_valid_d = dmi_valid_q;
        dmi_write_d = dmi_write_q;
        dmi_addr_d  = dmi_addr_q;
        dmi_wdata_d = dmi_wdata_q;
        result_d    = result_q;
        dmistat_d   = dmistat_q;

        // Handshake completes independently of anything happening on the TAP.
        if (dmi_valid_q && dmi_ready) begin
            dmi_valid_d = 1'b0;
            if (!dmi_write_q) begin
                result_d = dmi_rdata;
            end
        end

        if (st_tlr) begin
            ir_d       = IrIdcode;
            ir_shift_d = '0;
            dr_shift_d = '0;
        end else if (tck_rise) begin
            if (st_cap_ir) begin
                ir_shift_d = 5'b00001;
            end else if (st_shift_ir) begin
                ir_shift_d = {tdi_s, ir_shift_q[4:1]};
            end else if (st_upd_ir) begin
                ir_d = ir_shift_q;
            end else if (st_cap_dr) begin
                case (ir_q)
                    IrIdcode: dr_shift_d = {9'd0, IDCODE};
                    IrDtmcs:  dr_shift_d = {9'd0, dtmcs_capture};
                    IrDmi:    dr_shift_d = dmi_capture;
                    default:  dr_shift_d = '0;
                endcase
            end else if (st_shift_dr) begin
                // tdi enters at the MSB of whichever register IR selects.
                case (ir_q)
                    IrIdcode, IrDtmcs: dr_shift_d[31:0] = {tdi_s, dr_shift_q[31:1]};
                    IrDmi:             dr_shift_d       = {tdi_s, dr_shift_q[40:1]};
                    default:           dr_shift_d[0]    = tdi_s;
                endcase
            end else if (st_upd_dr) begin
                if (ir_q == IrDtmcs) begin
                    if (dr_shift_q[16] || dr_shift_q[17]) begin
                        dmistat_d = 2'd0;
                    end
                    if (dr_shift_q[17]) begin
                        dmi_valid_d = 1'b0;
                    end
                end else if (ir_q == IrDmi) begin
                    if ((dr_op == OpRead) || (dr_op == OpWrite)) begin
                        // Pending is judged on the registered valid, so an update that
                        // coincides with the handshake still counts as an overrun.
                        if (dmi_valid_q) begin
                            dmistat_d = 2'd3;
                        end else if (dmistat_q == 2'd0) begin
                            dmi_valid_d = 1'b1;
                            dmi_write_d = (dr_op == OpWrite);
                            dmi_addr_d  = dr_shift_q[40:34];
                            dmi_wdata_d = dr_shift_q[33:2];
                        end
                    end
                end
            end
        end

        if (!(st_shift_dr || st_shift_ir)) begin
            tdo_d = 1'b0;
        end else if (tck_fall) begin
            tdo_d = st_shift_ir ? ir_shift_q[0] : dr_shift_q[0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            tck_prev_q  <= 1'b0;
            state_q     <= StTlr;
            ir_q        <= IrIdcode;
            ir_shift_q  <= '0;
            dr_shift_q  <= '0;
            tdo_q       <= 1'b0;
            dmi_valid_q <= 1'b0;
            dmi_write_q <= 1'b0;
            dmi_addr_q  <= '0;
            dmi_wdata_q <= '0;
            result_q    <= '0;
            dmistat_q   <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tck_prev_q  <= tck_prev_d;
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_shift_q  <= ir_shift_d;
            dr_shift_q  <= dr_shift_d;
            tdo_q       <= tdo_d;
            dmi_valid_q <= dmi_valid_d;
            dmi_write_q <= dmi_write_d;
            dmi_addr_q  <= dmi_addr_d;
            dmi_wdata_q <= dmi_wdata_d;
            result_q    <= result_d;
            dmistat_q   <= dmistat_d;
        end
    end

    assign tdo       = tdo_q;
    assign dmi_valid = dmi_valid_q;
    assign dmi_write = dmi_write_q;
    assign dmi_addr  = dmi_addr_q;
    assign dmi_wdata = dmi_wdata_q;

endmodule

// File: tb/tb_dtm_jtag.sv
// ---------------------------------------------------------------------------------------------
// tb_dtm_jtag: directed self-checking bench for dtm_jtag.
// JTAG is driven at tck = clk/16. tdo is sampled just before each tck rising edge.
// ---------------------------------------------------------------------------------------------
module tb_dtm_jtag;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tck, tms, tdi;
    logic        tdo;
    logic        dmi_valid, dmi_ready, dmi_write;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata, dmi_rdata;

    int checks   = 0;
    int failures = 0;

    dtm_jtag #(.IDCODE(32'h1000_0001)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .dmi_valid (dmi_valid),
        .dmi_ready (dmi_ready),
        .dmi_write (dmi_write),
        .dmi_addr  (dmi_addr),
        .dmi_wdata (dmi_wdata),
        .dmi_rdata (dmi_rdata)
    );

    always #5 clk = ~clk;

    // One full tck period; returns tdo as seen just before the rising edge.
    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v;
        tdi = tdi_v;
        repeat (8) @(negedge clk);
        tdo_v = tdo;
        tck = 1'b1;
        repeat (8) @(negedge clk);
        tck = 1'b0;
    endtask

    // From Run-Test/Idle through an IR scan and back to Run-Test/Idle.
    task automatic scan_ir(input logic [4:0] v, output logic [4:0] o);
        logic b;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, v[i], b);
            o[i] = b;
        end
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
    endtask

    // From Run-Test/Idle through an n-bit DR scan and back to Run-Test/Idle.
    task automatic scan_dr(input logic [40:0] v, input int n, output logic [40:0] o);
        logic b;
        o = '0;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, v[i], b);
            o[i] = b;
        end
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
    endtask

    task automatic ready_pulse(input logic [31:0] rdata);
        dmi_rdata = rdata;
        dmi_ready = 1'b1;
        @(negedge clk);
        dmi_ready = 1'b0;
        dmi_rdata = 32'h0;
    endtask

    task automatic test_reset;
        logic [40:0] o;
        logic        b;
        resetn    = 1'b0;
        tck       = 1'b0;
        tms       = 1'b1;
        tdi       = 1'b0;
        dmi_ready = 1'b0;
        dmi_rdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dmi_valid, dmi_write, dmi_addr, dmi_wdata, tdo} !== 42'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b write=%b addr=%h wdata=%h tdo=%b, want all 0",
                     dmi_valid, dmi_write, dmi_addr, dmi_wdata, tdo);
        end
        resetn = 1'b1;
        @(negedge clk);
        tck_cycle(1'b0, 1'b0, b);
        scan_dr(41'd0, 32, o);
        checks++;
        if (o[31:0] !== 32'h1000_0001) begin
            failures++;
            $display("FAIL idcode_after_reset: got %h, want 10000001", o[31:0]);
        end
    endtask

    task automatic test_dtmcs_bypass;
        logic [40:0] o;
        logic [4:0]  oi;
        scan_ir(5'h10, oi);
        checks++;
        if (oi !== 5'b00001) begin
            failures++;
            $display("FAIL ir_capture: got %b, want 00001", oi);
        end
        scan_dr(41'd0, 32, o);
        checks++;
        if (o[31:0] !== 32'h0000_1071) begin
            failures++;
            $display("FAIL dtmcs_idle: got %h, want 00001071", o[31:0]);
        end
        scan_ir(5'h1F, oi);
        scan_dr(41'h0A5, 8, o);
        checks++;
        if (o[7:0] !== 8'h4A) begin
            failures++;
            $display("FAIL bypass: got %h, want 4a", o[7:0]);
        end
    endtask

    task automatic test_dmi_write;
        logic [40:0] o;
        logic [4:0]  oi;
        scan_ir(5'h11, oi);
        scan_dr({7'h04, 32'hDEAD_BEEF, 2'd2}, 41, o);
        checks++;
        if (o !== 41'd0) begin
            failures++;
            $display("FAIL dmi_first_capture: got %h, want 0", o);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({dmi_valid, dmi_write, dmi_addr, dmi_wdata} !== {1'b1, 1'b1, 7'h04, 32'hDEAD_BEEF})
            begin
                failures++;
                $display("FAIL write_hold_%0d: got valid=%b write=%b addr=%h wdata=%h, want 1 1 04 deadbeef",
                         k, dmi_valid, dmi_write, dmi_addr, dmi_wdata);
            end
        end
        ready_pulse(32'h0);
        checks++;
        if (dmi_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_done: got valid=%b, want 0", dmi_valid);
        end
    endtask

    task automatic test_dmi_read;
        logic [40:0] o;
        scan_dr({7'h04, 32'h0, 2'd1}, 41, o);
        checks++;
        if (o !== {7'h04, 32'h0, 2'd0}) begin
            failures++;
            $display("FAIL read_scan_capture: got %h, want %h", o, {7'h04, 32'h0, 2'd0});
        end
        checks++;
        if ({dmi_valid, dmi_write, dmi_addr} !== {1'b1, 1'b0, 7'h04}) begin
            failures++;
            $display("FAIL read_launch: got valid=%b write=%b addr=%h, want 1 0 04",
                     dmi_valid, dmi_write, dmi_addr);
        end
        ready_pulse(32'hDEAD_BEEF);
        scan_dr(41'd0, 41, o);
        checks++;
        if (o !== {7'h04, 32'hDEAD_BEEF, 2'd0}) begin
            failures++;
            $display("FAIL read_result: got %h, want %h", o, {7'h04, 32'hDEAD_BEEF, 2'd0});
        end
        checks++;
        if (dmi_valid !== 1'b0) begin
            failures++;
            $display("FAIL nop_no_launch: got valid=%b, want 0", dmi_valid);
        end
    endtask

    task automatic test_busy;
        logic [40:0] o;
        logic [4:0]  oi;
        scan_dr({7'h09, 32'h0, 2'd1}, 41, o);
        scan_dr({7'h05, 32'h0000_1234, 2'd2}, 41, o);
        checks++;
        if (o[1:0] !== 2'd3) begin
            failures++;
            $display("FAIL busy_capture_pending: got op=%0d, want 3", o[1:0]);
        end
        checks++;
        if ({dmi_valid, dmi_write, dmi_addr, dmi_wdata} !== {1'b1, 1'b0, 7'h09, 32'h0}) begin
            failures++;
            $display("FAIL busy_no_relaunch: got valid=%b write=%b addr=%h wdata=%h, want 1 0 09 0",
                     dmi_valid, dmi_write, dmi_addr, dmi_wdata);
        end
        scan_dr(41'd0, 41, o);
        checks++;
        if (o[1:0] !== 2'd3) begin
            failures++;
            $display("FAIL busy_capture_sticky: got op=%0d, want 3", o[1:0]);
        end
        scan_ir(5'h10, oi);
        scan_dr(41'd0, 32, o);
        checks++;
        if (o[31:0] !== 32'h0000_1C71) begin
            failures++;
            $display("FAIL dtmcs_busy: got %h, want 00001c71", o[31:0]);
        end
        ready_pulse(32'h0BAD_F00D);
        scan_dr(41'h1_0000, 32, o);
        checks++;
        if (o[31:0] !== 32'h0000_1C71) begin
            failures++;
            $display("FAIL dtmcs_still_sticky: got %h, want 00001c71", o[31:0]);
        end
        scan_dr(41'd0, 32, o);
        checks++;
        if (o[31:0] !== 32'h0000_1071) begin
            failures++;
            $display("FAIL dmireset_clears: got %h, want 00001071", o[31:0]);
        end
        scan_ir(5'h11, oi);
        scan_dr(41'd0, 41, o);
        checks++;
        if (o !== {7'h09, 32'h0BAD_F00D, 2'd0}) begin
            failures++;
            $display("FAIL busy_read_result: got %h, want %h", o, {7'h09, 32'h0BAD_F00D, 2'd0});
        end
    endtask

    task automatic test_tlr_and_async_reset;
        logic [40:0] o;
        logic        b;
        scan_dr({7'h03, 32'h0, 2'd1}, 41, o);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(1'b1, 1'b0, b);
        end
        checks++;
        if ({dmi_valid, dmi_addr} !== {1'b1, 7'h03}) begin
            failures++;
            $display("FAIL tlr_keeps_pending: got valid=%b addr=%h, want 1 03", dmi_valid, dmi_addr);
        end
        tck_cycle(1'b0, 1'b0, b);
        scan_dr(41'd0, 32, o);
        checks++;
        if (o[31:0] !== 32'h1000_0001) begin
            failures++;
            $display("FAIL tlr_ir_idcode: got %h, want 10000001", o[31:0]);
        end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({dmi_valid, dmi_write, dmi_addr, dmi_wdata, tdo} !== 42'd0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b write=%b addr=%h wdata=%h tdo=%b, want all 0",
                     dmi_valid, dmi_write, dmi_addr, dmi_wdata, tdo);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        tck_cycle(1'b0, 1'b0, b);
        scan_dr(41'd0, 32, o);
        checks++;
        if (o[31:0] !== 32'h1000_0001) begin
            failures++;
            $display("FAIL idcode_after_async_reset: got %h, want 10000001", o[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_dtmcs_bypass();
        test_dmi_write();
        test_dmi_read();
        test_busy();
        test_tlr_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dtm_jtag.md
DTM_JTAG -- requirements
Module: dtm_jtag

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1000_0001, value returned by the IDCODE data register.
REQ-002 SHALL have ports: clk  input  1  system clock; all state clocked on posedge clk.
REQ-003 SHALL have: resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have: tck, tms, tdi  input  1 each  JTAG pins, asynchronous to clk.
REQ-005 SHALL have: tdo  output  1  JTAG serial data out.
REQ-006 SHALL have: dmi_valid  output 1; dmi_ready  input 1; dmi_write  output 1; dmi_addr  output 7; dmi_wdata  output 32; dmi_rdata  input 32. These form the DMI initiator port.

Function
REQ-007 SHALL synchronise tck, tms and tdi through two clk flops each.
REQ-008 SHALL detect tck rising and falling edges from the synchronised tck; tck frequency SHALL be at most clk/8.
REQ-009 SHALL advance the 16-state IEEE 1149.1 TAP controller on each tck rising edge, using synchronised tms.
REQ-010 In Shift-IR and Shift-DR, on each tck rising edge, SHALL shift the selected register right one bit, LSB first, with tdi entering the MSB.
REQ-011 SHALL update tdo on each tck falling edge with shift[0] while in a Shift state; otherwise tdo SHALL hold 0.
REQ-012 SHALL use a 5-bit IR:
- Capture-IR loads 5'b00001.
- Update-IR latches the shifted value.
- Test-Logic-Reset forces IR to 5'h01.
REQ-013 SHALL decode IR as: 5'h01 IDCODE (32b); 5'h10 DTMCS (32b); 5'h11 DMI (41b); all other values BYPASS (1b, captures 0).
REQ-014 DTMCS capture value SHALL be:
- version = 1 at [3:0];
- abits = 7 at [9:4];
- dmistat at [11:10];
- idle = 1 at [14:12];
- all other bits 0.
REQ-015 On DTMCS Update-DR, bit 16 (dmireset) or bit 17 (dmihardreset) SHALL clear sticky dmistat.
REQ-016 On DTMCS Update-DR, bit 17 SHALL additionally drop any pending dmi_valid in the next clk.
REQ-017 DMI register layout SHALL be {addr[40:34], data[33:2], op[1:0]}.
REQ-018 DMI Capture-DR SHALL load last addr, last result data, and op:
- op = 3 if a transaction is pending or dmistat is sticky busy;
- otherwise op = 0.
REQ-019 DMI Update-DR with op=1 (read) or op=2 (write), no pending transaction and dmistat=0 SHALL set dmi_valid=1 in the following clk.
REQ-020 The same launch SHALL drive dmi_addr/dmi_wdata from the register and set dmi_write=(op==2).
REQ-021 DMI Update-DR with op=0 or op=3 SHALL launch nothing.
REQ-022 DMI Update-DR with op 1/2 while a transaction is pending SHALL set sticky dmistat=3 and SHALL NOT launch.
REQ-023 dmi_valid, dmi_addr, dmi_wdata and dmi_write SHALL hold stable until the clk cycle where dmi_valid && dmi_ready.
REQ-024 In the dmi_valid && dmi_ready cycle:
- dmi_valid SHALL go 0 next clk;
- for a read, dmi_rdata SHALL be latched into result data;
- for a write, result data SHALL be unchanged.
REQ-025 Entering Test-Logic-Reset via tms SHALL reset IR and the DTMCS/DMI shift registers, and SHALL NOT abort a pending DMI transaction.
REQ-026 A pending transaction SHALL complete regardless of TAP activity; simultaneous completion and Update-DR SHALL count the transaction as still pending.

Reset
REQ-027 On resetn low, outputs SHALL be forced immediately and held:
- dmi_valid=0, dmi_write=0, dmi_addr=0, dmi_wdata=0;
- tdo=0.
REQ-028 On resetn low, internal state SHALL be forced immediately and held:
- TAP state = Test-Logic-Reset, IR = 5'h01;
- dmistat=0, result data=0, last addr=0;
- synchroniser flops = 0.
REQ-029 Normal operation SHALL resume on the first clk edge after resetn rises.

Verification
REQ-030 Reset, then Run-Test/Idle → Shift-DR, shift 32 bits → tdo returns 32'h1000_0001, LSB first.
REQ-031 Shift IR=5'h10, then scan DR 32 bits → tdo returns 32'h0000_1071.
REQ-032 IR=5'h11, scan in {7'h04, 32'hDEADBEEF, 2'd2}, Update-DR → next clk dmi_valid=1, dmi_write=1, dmi_addr=7'h04, dmi_wdata=32'hDEADBEEF; these hold through 5 clks of dmi_ready=0; dmi_valid=0 one clk after the ready cycle.
REQ-033 Scan a read {7'h04, 0, 2'd1}; responder returns dmi_rdata=32'hDEADBEEF; next DMI scan shifts out data=32'hDEADBEEF, op=0.
REQ-034 Launch a read with dmi_ready held 0, then issue a second write Update-DR:
- no second launch; next capture op=3; DTMCS dmistat=3;
- DTMCS write with bit16=1 → dmistat=0.
REQ-035 Drop resetn while dmi_valid=1 → dmi_valid=0 without a clk edge; first IDCODE scan after release returns 32'h1000_0001.
